// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default sizes for the IF/MEM memory port arbiter
//
// Contents:
//   ARB_ADDR_W, ARB_DATA_W, ARB_TIMEOUT  default parameter values for mem_port_arbiter
//   arb_state_e                          arbiter state encoding (IDLE, D_ACC, I_ACC, ERR)
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W  = 32;
    localparam int unsigned ARB_DATA_W  = 32;
    localparam int unsigned ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        ERR   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - request-cycle counter that flags an unacknowledged memory access
//
// Ports:
//   clk_i      clock
//   rst_i      asynchronous reset, active-low
//   clear_i    restart the count; with en_i also high, the current cycle is counted as the first
//   en_i       count the current request cycle
//   expired_o  the current cycle is the LIMIT-th request cycle of this access
module arb_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q holds how many request cycles of the current access have already elapsed,
    // so the LIMIT-th cycle is the one that sees LIMIT-1.
    assign expired_o = (cnt_q >= CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = en_i ? CNT_W'(1) : '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data access
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-low reset
//   start_i                            grant enable; low blocks new grants only
//   if_req_i, if_addr_i                fetch request / address
//   if_rdata_o, if_done_o              registered fetch data / fetch complete this pipeline cycle
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                         data request, store flag, address, store data
//   dm_rdata_o, dm_done_o              registered load data / data access complete
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                        memory request channel
//   mem_ack_i, mem_rdata_i             memory acknowledge and read data
//   stall_o                            combinational pipeline stall
//   stall_cnt_o                        count of stalled cycles while enabled
//   err_o                              sticky memory timeout
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ARB_ADDR_W,
    parameter int unsigned DATA_W  = ARB_DATA_W,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [31:0]       stall_cnt_o,
    output logic              err_o
);

    arb_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              we_q,        we_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              dm_done_q,   dm_done_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic              err_q,       err_d;

    logic if_pend;
    logic dm_pend;
    logic in_acc;
    logic stall_w;
    logic issue;
    logic go_dacc;
    logic go_iacc;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign if_pend = if_req_i & ~if_done_q;
    assign dm_pend = dm_req_i & ~dm_done_q;
    assign in_acc  = (state_q == D_ACC) || (state_q == I_ACC);

    // Outputs are forced low while reset is held, including the combinational ones.
    assign stall_w = rst_i & (if_pend | dm_pend | (state_q == ERR));

    // The first request cycle is issued straight from IDLE using the live request
    // inputs, so a zero-wait memory completes an access in a single stalled cycle.
    // If that cycle is not acknowledged the request is latched and held in D_ACC/I_ACC.
    assign issue = rst_i & start_i & (state_q == IDLE) & (dm_pend | if_pend);

    assign mem_req_o   = issue | in_acc;
    assign mem_we_o    = issue ? (dm_pend & dm_we_i) : ((state_q == D_ACC) & we_q);
    assign mem_addr_o  = issue ? (dm_pend ? dm_addr_i : if_addr_i) : addr_q;
    assign mem_wdata_o = issue ? (dm_pend ? dm_wdata_i : '0) : wdata_q;

    assign stall_o     = stall_w;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_done_o   = if_done_q;
    assign dm_done_o   = dm_done_q;
    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

    arb_timeout_counter #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = if_done_q;
        dm_done_d   = dm_done_q;
        err_d       = err_q;
        go_dacc     = 1'b0;
        go_iacc     = 1'b0;
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        stall_cnt_d = stall_cnt_q + {{31{1'b0}}, stall_w & start_i};

        // Pipeline advances: forget what was served. Sets below override this.
        if (!stall_w) begin
            if_done_d = 1'b0;
            dm_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (issue) begin
                    if (mem_ack_i) begin
                        if (dm_pend) begin
                            dm_done_d = 1'b1;
                            if (!dm_we_i) dm_rdata_d = mem_rdata_i;
                            // issue implies start_i, so the fetch may follow immediately
                            if (if_pend) go_iacc = 1'b1;
                        end else begin
                            if_done_d  = 1'b1;
                            if_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        timer_en = 1'b1;
                        if (dm_pend) go_dacc = 1'b1;
                        else         go_iacc = 1'b1;
                    end
                end
            end
            D_ACC: begin
                if (mem_ack_i) begin
                    dm_done_d = 1'b1;
                    if (!we_q) dm_rdata_d = mem_rdata_i;
                    if (if_pend && start_i) go_iacc = 1'b1;
                    else                    state_d = IDLE;
                end else if (timer_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    timer_clear = 1'b0;
                    timer_en    = 1'b1;
                end
            end
            I_ACC: begin
                if (mem_ack_i) begin
                    if_done_d  = 1'b1;
                    if_rdata_d = mem_rdata_i;
                    if (dm_pend && start_i) go_dacc = 1'b1;
                    else                    state_d = IDLE;
                end else if (timer_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    timer_clear = 1'b0;
                    timer_en    = 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_dacc) begin
            state_d = D_ACC;
            addr_d  = dm_addr_i;
            we_d    = dm_we_i;
            wdata_d = dm_wdata_i;
        end
        if (go_iacc) begin
            state_d = I_ACC;
            addr_d  = if_addr_i;
            we_d    = 1'b0;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule
